// File: rtl/vram_arbiter.sv
// Arbitrates the 32Kx8 VRAM between the seq-7 video fetch and FIFO-buffered CPU writes.
// Optional write coalescing into the newest FIFO entry: define VRAM_WR_COALESCE_EN.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pixClock,
  input  logic        reset,
  input  logic [2:0]  seq,
  input  logic        vidReq,
  input  logic [14:0] vidAddr,
  input  logic        cpuWrReq,
  input  logic [14:0] cpuWrAddr,
  input  logic [7:0]  cpuWrData,
  output logic [14:0] vramAddr,
  output logic [7:0]  vramDataOut,
  output logic        vramDataOe,
  output logic        nvramOE,
  output logic        nvramWE,
  output logic        fifoFull,
  output logic        fifoOverflow,
  output logic [1:0]  dbgState
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WSETUP  = 2'd1,
    WSTROBE = 2'd2,
    WHOLD   = 2'd3
  } wrState_t;

  wrState_t      state;
  logic [14:0]   memAddr [FIFO_DEPTH];
  logic [7:0]    memData [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic [2:0]    nextSeq;
  logic          readActive;
  logic          fifoEmpty;
  logic          startOk;
  logic          pop;
  logic          doPush;
  logic          doCoalesce;

  // cpuWrReq is a one-cycle strobe with no ready: a push is taken when there is
  // room (or a pop in the same cycle frees one), otherwise it is dropped and
  // fifoOverflow latches; fifoFull is advisory to the snoop front end.
  assign readActive = vidReq && (seq == 3'd7);
  assign fifoEmpty  = (count == '0);
  assign nextSeq    = seq + 3'd1;
  // The decision is taken one cycle ahead, so a write starting in seq 0..4
  // finishes by seq 6 and never meets the seq-7 fetch in normal scan-out.
  assign startOk    = !fifoEmpty && (nextSeq <= 3'd4);
  assign pop        = (state == WHOLD) && !readActive;

`ifdef VRAM_WR_COALESCE_EN
  logic [PW-1:0] newestPtr;
  assign newestPtr  = wrPtr - PW'(1);
  // The head entry is frozen while it is on the VRAM pins.
  assign doCoalesce = cpuWrReq && !fifoEmpty && (memAddr[newestPtr] == cpuWrAddr) &&
                      !((newestPtr == rdPtr) && (state != IDLE));
`else
  assign doCoalesce = 1'b0;
`endif

  assign doPush    = cpuWrReq && !doCoalesce && (!fifoFull || pop);
  assign countNext = count + CW'(doPush) - CW'(pop);

  always_ff @(posedge pixClock or posedge reset) begin
    if (reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      fifoFull     <= 1'b0;
      fifoOverflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        memAddr[i] <= '0;
        memData[i] <= '0;
      end
    end else begin
      if (doPush) begin
        memAddr[wrPtr] <= cpuWrAddr;
        memData[wrPtr] <= cpuWrData;
        wrPtr          <= wrPtr + PW'(1);
      end
`ifdef VRAM_WR_COALESCE_EN
      if (doCoalesce) begin
        memData[newestPtr] <= cpuWrData;
      end
`endif
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      count    <= countNext;
      fifoFull <= (countNext == FULL_COUNT);
      if (cpuWrReq && !doCoalesce && !doPush) begin
        fifoOverflow <= 1'b1;
      end
    end
  end

  // A fetch landing on an active write (seq jumped) aborts it; the head stays
  // queued and the whole three-cycle write is replayed later.
  always_ff @(posedge pixClock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= startOk ? WSETUP : IDLE;
        WSETUP:  state <= readActive ? IDLE : WSTROBE;
        WSTROBE: state <= readActive ? IDLE : WHOLD;
        WHOLD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    vramAddr    = readActive ? vidAddr : memAddr[rdPtr];
    vramDataOut = memData[rdPtr];
    vramDataOe  = (state != IDLE) && !readActive;
    nvramOE     = !readActive;
    nvramWE     = !((state == WSTROBE) && !readActive);
    dbgState    = state;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: free-running seq, per-scenario tasks and a
// VRAM write monitor scoring observed writes against an expected queue.
module tb_vram_arbiter;

  logic        pixClock = 1'b0;
  logic        reset;
  logic [2:0]  seq;
  logic        vidReq;
  logic [14:0] vidAddr;
  logic        cpuWrReq;
  logic [14:0] cpuWrAddr;
  logic [7:0]  cpuWrData;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        vramDataOe;
  logic        nvramOE;
  logic        nvramWE;
  logic        fifoFull;
  logic        fifoOverflow;
  logic [1:0]  dbgState;

  int          checks = 0;
  int          failures = 0;
  int          winCnt = 0;
  bit          monEn = 1'b0;
  logic [22:0] exp_q[$];

  vram_arbiter #(.FIFO_DEPTH(4)) dut (
    .pixClock(pixClock), .reset(reset), .seq(seq), .vidReq(vidReq), .vidAddr(vidAddr),
    .cpuWrReq(cpuWrReq), .cpuWrAddr(cpuWrAddr), .cpuWrData(cpuWrData),
    .vramAddr(vramAddr), .vramDataOut(vramDataOut), .vramDataOe(vramDataOe),
    .nvramOE(nvramOE), .nvramWE(nvramWE), .fifoFull(fifoFull),
    .fifoOverflow(fifoOverflow), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #20 pixClock = ~pixClock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic advanceTo(input logic [2:0] s);
    @(posedge pixClock);
    #1;
    if (s == 3'd0) winCnt++;
    seq      = s;
    vidReq   = (s == 3'd7);
    vidAddr  = 15'h6000 + 15'(winCnt);
    cpuWrReq = 1'b0;
  endtask

  task automatic advance();
    advanceTo(seq + 3'd1);
  endtask

  task automatic push(input logic [14:0] a, input logic [7:0] d, input bit expectIt);
    cpuWrReq  = 1'b1;
    cpuWrAddr = a;
    cpuWrData = d;
    if (expectIt) exp_q.push_back({a, d});
  endtask

  task automatic waitSeq(input logic [2:0] s, input string name);
    int n = 0;
    while (seq != s && n < 16) begin
      advance();
      n++;
    end
    checks++;
    if (seq !== s) begin
      failures++;
      $display("FAIL %s_wait: seq=%0d want %0d", name, seq, s);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) advance();
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prevOe;
  logic        prevWe;
  logic [14:0] prevAddr;
  logic [7:0]  prevData;

  always @(negedge pixClock) begin
    logic [22:0] expW;
    if (reset || !monEn) begin
      prevOe = 1'b0;
      prevWe = 1'b1;
    end else begin
      checks++;
      if (nvramOE !== !(vidReq && seq == 3'd7)) begin
        failures++;
        $display("FAIL mon_oe: seq=%0d vidReq=%b nvramOE=%b", seq, vidReq, nvramOE);
      end
      if (vidReq && seq == 3'd7) begin
        checks++;
        if (vramAddr !== vidAddr || nvramWE !== 1'b1 || vramDataOe !== 1'b0) begin
          failures++;
          $display("FAIL mon_read_slot: addr=%h want %h we=%b oe=%b want 1/0",
                   vramAddr, vidAddr, nvramWE, vramDataOe);
        end
      end
      if (nvramWE === 1'b0) begin
        checks++;
        if (!(prevOe === 1'b1 && prevAddr === vramAddr && prevData === vramDataOut &&
              vramDataOe === 1'b1)) begin
          failures++;
          $display("FAIL mon_wr_setup: addr=%h/%h data=%h/%h prevOe=%b oe=%b",
                   vramAddr, prevAddr, vramDataOut, prevData, prevOe, vramDataOe);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_wr_unexpected: addr=%h data=%h, no write expected",
                   vramAddr, vramDataOut);
        end else begin
          expW = exp_q.pop_front();
          if ({vramAddr, vramDataOut} !== expW) begin
            failures++;
            $display("FAIL mon_wr_order: got %h/%h want %h/%h",
                     vramAddr, vramDataOut, expW[22:8], expW[7:0]);
          end
        end
      end
      if (prevWe === 1'b0) begin
        checks++;
        if (!(vramDataOe === 1'b1 && nvramWE === 1'b1 && vramAddr === prevAddr &&
              vramDataOut === prevData)) begin
          failures++;
          $display("FAIL mon_wr_hold: addr=%h want %h data=%h want %h oe=%b we=%b",
                   vramAddr, prevAddr, vramDataOut, prevData, vramDataOe, nvramWE);
        end
      end
      prevOe   = vramDataOe;
      prevWe   = nvramWE;
      prevAddr = vramAddr;
      prevData = vramDataOut;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    #5;
    checks++;
    if ({nvramOE, nvramWE, vramDataOe} !== 3'b110) begin
      failures++;
      $display("FAIL reset_ctrl: oe/we/dataOe=%b want 110", {nvramOE, nvramWE, vramDataOe});
    end
    checks++;
    if (vramAddr !== 15'h0 || vramDataOut !== 8'h0) begin
      failures++;
      $display("FAIL reset_bus: addr=%h data=%h want 0/0", vramAddr, vramDataOut);
    end
    checks++;
    if ({fifoFull, fifoOverflow} !== 2'b00 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags: full=%b ovf=%b state=%0d want 0/0/0",
               fifoFull, fifoOverflow, dbgState);
    end
    repeat (2) advance();
    reset = 1'b0;
    monEn = 1'b1;
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd0 || vramDataOe !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: state=%0d oe=%b want 0/0", dbgState, vramDataOe);
    end
  endtask

  task automatic test_single_write();
    waitSeq(3'd6, "single");
    push(15'h1234, 8'hA5, 1'b1);
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd0 || nvramOE !== 1'b0 || vramAddr !== vidAddr) begin
      failures++;
      $display("FAIL single_seq7: state=%0d nvramOE=%b addr=%h want 0/0/%h",
               dbgState, nvramOE, vramAddr, vidAddr);
    end
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd1 || vramAddr !== 15'h1234 || vramDataOut !== 8'hA5 ||
        vramDataOe !== 1'b1 || nvramWE !== 1'b1) begin
      failures++;
      $display("FAIL single_setup: state=%0d addr=%h data=%h oe=%b we=%b want 1/1234/a5/1/1",
               dbgState, vramAddr, vramDataOut, vramDataOe, nvramWE);
    end
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd2 || nvramWE !== 1'b0) begin
      failures++;
      $display("FAIL single_strobe: state=%0d we=%b want 2/0", dbgState, nvramWE);
    end
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd3 || nvramWE !== 1'b1) begin
      failures++;
      $display("FAIL single_hold: state=%0d we=%b want 3/1", dbgState, nvramWE);
    end
    for (int c = 0; c < 6; c++) begin
      advance();
      @(negedge pixClock);
      checks++;
      if (dbgState !== 2'd0 || vramDataOe !== 1'b0) begin
        failures++;
        $display("FAIL single_idle: seq=%0d state=%0d oe=%b want 0/0", seq, dbgState, vramDataOe);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_done: pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_burst_overflow();
    logic [1:0] expSt;
    waitSeq(3'd3, "burst");
    for (int c = 0; c < 21; c++) begin
      if (c > 0) advance();
      if (c < 6) push(15'h0200 + 15'(c), 8'h30 + 8'(c), c < 4);
      @(negedge pixClock);
      expSt = (c < 5 || seq[1:0] == 2'd3) ? 2'd0 : seq[1:0] + 2'd1;
      checks++;
      if (dbgState !== expSt) begin
        failures++;
        $display("FAIL burst_state: c=%0d seq=%0d state=%0d want %0d", c, seq, dbgState, expSt);
      end
      if (c == 4) begin
        checks++;
        if (fifoFull !== 1'b1 || fifoOverflow !== 1'b0) begin
          failures++;
          $display("FAIL burst_full: full=%b ovf=%b want 1/0", fifoFull, fifoOverflow);
        end
      end
      if (c == 5) begin
        checks++;
        if (fifoOverflow !== 1'b1) begin
          failures++;
          $display("FAIL burst_overflow: ovf=%b want 1", fifoOverflow);
        end
      end
      if (c == 8) begin
        checks++;
        if (fifoFull !== 1'b0) begin
          failures++;
          $display("FAIL burst_unfull: full=%b want 0", fifoFull);
        end
      end
    end
    repeat (8) advance();
    @(negedge pixClock);
    checks++;
    if (exp_q.size() != 0 || dbgState !== 2'd0 || fifoOverflow !== 1'b1) begin
      failures++;
      $display("FAIL burst_drain: pending=%0d state=%0d ovf=%b want 0/0/1",
               exp_q.size(), dbgState, fifoOverflow);
    end
  endtask

  task automatic test_full_push_pop();
    waitSeq(3'd3, "fullpp");
    for (int c = 0; c < 13; c++) begin
      if (c > 0) advance();
      if (c < 4) push(15'h0400 + 15'(c), 8'h50 + 8'(c), 1'b1);
      if (c == 7) push(15'h0404, 8'h54, 1'b1);
      @(negedge pixClock);
      if (c == 7) begin
        checks++;
        if (dbgState !== 2'd3 || fifoFull !== 1'b1) begin
          failures++;
          $display("FAIL fullpp_popcycle: state=%0d full=%b want 3/1", dbgState, fifoFull);
        end
      end
      if (c == 8) begin
        checks++;
        if (fifoFull !== 1'b1 || fifoOverflow !== 1'b0) begin
          failures++;
          $display("FAIL fullpp_after: full=%b ovf=%b want 1/0", fifoFull, fifoOverflow);
        end
      end
    end
    repeat (24) advance();
    @(negedge pixClock);
    checks++;
    if (exp_q.size() != 0 || fifoFull !== 1'b0 || fifoOverflow !== 1'b0 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL fullpp_drain: pending=%0d full=%b ovf=%b state=%0d want 0/0/0/0",
               exp_q.size(), fifoFull, fifoOverflow, dbgState);
    end
  endtask

  task automatic test_collision();
    logic [1:0] expSt;
    waitSeq(3'd2, "collision");
    push(15'h0ABC, 8'h5A, 1'b1);
    advance();
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd1) begin
      failures++;
      $display("FAIL coll_setup: state=%0d want 1", dbgState);
    end
    advanceTo(3'd7);
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd2 || nvramWE !== 1'b1 || vramDataOe !== 1'b0 ||
        nvramOE !== 1'b0 || vramAddr !== vidAddr) begin
      failures++;
      $display("FAIL coll_read_wins: state=%0d we=%b oe=%b noe=%b addr=%h want 2/1/0/0/%h",
               dbgState, nvramWE, vramDataOe, nvramOE, vramAddr, vidAddr);
    end
    for (int c = 0; c < 5; c++) begin
      advance();
      @(negedge pixClock);
      expSt = (c == 0 || c == 4) ? 2'd0 : 2'(c);
      checks++;
      if (dbgState !== expSt) begin
        failures++;
        $display("FAIL coll_retry: seq=%0d state=%0d want %0d", seq, dbgState, expSt);
      end
    end
    repeat (8) advance();
    @(negedge pixClock);
    checks++;
    if (exp_q.size() != 0 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL coll_done: pending=%0d state=%0d want 0/0", exp_q.size(), dbgState);
    end
  endtask

  task automatic test_coalesce();
    waitSeq(3'd6, "coalesce");
    push(15'h0300, 8'h77, 1'b1);
    advance();
    advance();
    @(negedge pixClock);
    checks++;
    if (dbgState !== 2'd1) begin
      failures++;
      $display("FAIL coal_busy: state=%0d want 1", dbgState);
    end
`ifdef VRAM_WR_COALESCE_EN
    push(15'h0100, 8'h11, 1'b0);
    advance();
    push(15'h0100, 8'h22, 1'b1);
`else
    push(15'h0100, 8'h11, 1'b1);
    advance();
    push(15'h0100, 8'h22, 1'b1);
`endif
    repeat (20) advance();
    @(negedge pixClock);
    checks++;
    if (exp_q.size() != 0 || fifoOverflow !== 1'b0 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL coal_done: pending=%0d ovf=%b state=%0d want 0/0/0",
               exp_q.size(), fifoOverflow, dbgState);
    end
  endtask

  task automatic test_reset_mid_write();
    waitSeq(3'd5, "rstmid");
    push(15'h0555, 8'hC3, 1'b0);
    advance();
    push(15'h0666, 8'h3C, 1'b0);
    advance();
    advance();
    advance();
    #5;
    checks++;
    if (nvramWE !== 1'b0 || dbgState !== 2'd2) begin
      failures++;
      $display("FAIL rstmid_strobe: we=%b state=%0d want 0/2", nvramWE, dbgState);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (nvramWE !== 1'b1 || vramDataOe !== 1'b0 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_release: we=%b oe=%b state=%0d want 1/0/0", nvramWE, vramDataOe, dbgState);
    end
    exp_q.delete();
    repeat (2) advance();
    reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      advance();
      @(negedge pixClock);
      checks++;
      if (dbgState !== 2'd0 || fifoOverflow !== 1'b0 || fifoFull !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_empty: seq=%0d state=%0d ovf=%b full=%b want 0/0/0",
                 seq, dbgState, fifoOverflow, fifoFull);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset     = 1'b0;
    seq       = 3'd0;
    vidReq    = 1'b0;
    vidAddr   = 15'h0;
    cpuWrReq  = 1'b0;
    cpuWrAddr = 15'h0;
    cpuWrData = 8'h0;
    #1;
    test_reset();
    test_single_write();
    test_burst_overflow();
    applyReset();
    test_full_push_pop();
    test_collision();
    test_coalesce();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single 32K×8 VRAM between the VGA scan-out fetch and snooped 68000 framebuffer writes. Buffers CPU writes in a small FIFO and sequences each one as a three-cycle SRAM write cycle in the pixel slots not used by the video fetch (sequence 7). Sits between the bus-snoop front end and the VRAM pins. Replaces the direct `nvramOE`/address hookup so that the CPU/video address mux is no longer external.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, number of buffered CPU writes; power of two, 2..16.

Ports:
- `pixClock`  in  1  pixel clock, 25.175 MHz; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `seq`  in  3  `hCount[2:0]`, pixel position within the current byte.
- `vidReq`  in  1  video fetch request; valid only when `seq`==7.
- `vidAddr`  in  15  video fetch address, `{vCount[8:0],hCount[8:3]}`.
- `cpuWrReq`  in  1  single-cycle push strobe, already synchronised to `pixClock`.
- `cpuWrAddr`  in  15  VRAM byte address of the CPU write.
- `cpuWrData`  in  8  CPU write data.
- `vramAddr`  out  15  VRAM address pins.
- `vramDataOut`  out  8  write data to the VRAM data bus.
- `vramDataOe`  out  1  high = drive `vramDataOut` onto the bus.
- `nvramOE`  out  1  VRAM output enable, active low.
- `nvramWE`  out  1  VRAM write enable, active low.
- `fifoFull`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `fifoOverflow`  out  1  sticky; a push was dropped.

## Operation
- **Read path:** when `vidReq`=1 and `seq`=7, `nvramOE`=0 and `vramAddr`=`vidAddr`. Both are decoded combinationally from the inputs and the registered state. Read has absolute priority.
- **FIFO:**
  - `cpuWrReq`=1 and not full: push `{addr,data}`.
  - Full: drop the push and set `fifoOverflow`.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
  - The head entry is popped only on successful completion (WHOLD→IDLE).
- **Write FSM:** states IDLE, WSETUP, WSTROBE, WHOLD.
  - IDLE→WSETUP when the FIFO is non-empty, `seq`∈{0..4}, and no read is active.
  - WSETUP→WSTROBE→WHOLD→IDLE, one cycle each, unconditionally.
  - At most two writes per byte window: starting at `seq` 0 occupies 0–2; the next start is at `seq` 4 and occupies 4–6. `seq` 7 is always free for the read.
- **Outputs by state:**
  - WSETUP/WSTROBE/WHOLD: `vramAddr`=head address, `vramDataOut`=head data, `vramDataOe`=1.
  - WSTROBE only: `nvramWE`=0.
  - IDLE with no read: `vramAddr`=head address (don't-care), `vramDataOe`=0, `nvramOE`=1, `nvramWE`=1.
- **Collision:** if `vidReq`=1 at `seq`=7 while the FSM is not IDLE (only possible if `seq` jumps):
  - the read wins;
  - `nvramWE` is forced 1 and `vramDataOe` is forced 0 in that cycle;
  - the FSM returns to IDLE, the head is not popped, and the write is retried from WSETUP later.
- **`vramDataOut`:** holds the last head data when not driving; value is irrelevant.

## Timing
- **Reset values:**
  - `nvramOE`=1, `nvramWE`=1, `vramDataOe`=0
  - `vramAddr`=0, `vramDataOut`=0
  - `fifoFull`=0, `fifoOverflow`=0
  - FIFO empty, FSM IDLE
  - Reset asserted mid-write releases `nvramWE` immediately (asynchronously). Queued writes are lost.
- **Latency:** a push at edge N into an empty FIFO starts WSETUP at the first edge ≥N+1 where `seq`∈{0..4}. `nvramWE` falls one cycle after WSETUP.
- **Write cycle:** address and data are stable one full cycle before and one full cycle after `nvramWE` is low (about 39.7 ns each side).
- **`fifoFull`:** registered from the count; updates on the edge after the push or pop.
- **Pointers:** wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.

## Configuration
- **`VRAM_WR_COALESCE_EN` defined:**
  - A push whose address equals the newest FIFO entry's address overwrites that entry's data instead of allocating a new entry.
  - This applies even when the FIFO is full (no overflow).
  - Exception: if the newest entry is the head and the FSM is not IDLE, a new entry is allocated normally.
- **Undefined:** every push allocates an entry, and no address comparator is built.

## Test plan
- **Reset mid-write:** assert `reset` during WSTROBE → `nvramWE`=1 and `vramDataOe`=0 in the same cycle; FIFO empty; `fifoOverflow`=0 after release.
- **Single write:** push `addr`=15'h1234, `data`=8'hA5 at `seq`=6 → WSETUP at `seq`=0, `nvramWE` low only at `seq`=1, FIFO empty after `seq`=2; `nvramOE` low at `seq`=7 with `vramAddr`=`vidAddr`.
- **Burst and overflow:** 6 back-to-back pushes with `FIFO_DEPTH`=4 → 4 accepted, `fifoOverflow`=1. Writes complete in order at `seq` 0–2 and 4–6 of consecutive windows. No write overlaps `seq`=7.
- **Full push/pop:** FIFO full; push in the WHOLD→IDLE pop cycle → push accepted, count stays 4, `fifoOverflow` stays 0.
- **Collision:** force `seq` 4→7 during WSTROBE with `vidReq`=1 → read wins, the write is aborted and retried, and the head data eventually reaches VRAM exactly once with a full three-cycle strobe.
- **Coalesce (`VRAM_WR_COALESCE_EN`):** pushes 0x0100/0x11 then 0x0100/0x22 while the FSM is busy with another entry → one write of 0x22 to 0x0100. Without the macro → two writes, 0x11 then 0x22.
